// File: rtl/gecko_data_router.sv
// gecko_data_router
//   Routes gecko_core data-port requests to main memory, MMIO or an internal
//   "unmapped" responder. Read results are returned to the core in the order
//   the reads were issued. A small FIFO of destination codes records where
//   each outstanding read went, and the FIFO head picks the result source.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   core_request_*   (slave)      valid/ready, read_enable, write_enable, addr, data
//   core_result_*    (master)     valid/ready, data -- in-order read results
//   mem_command_*    (master)     request forwarded to main memory
//   mem_result_*     (slave)      read data from main memory
//   mmio_command_*   (master)     request forwarded to MMIO space
//   mmio_result_*    (slave)      read data from MMIO
//   fault_flag                    sticky, set by any accepted unmapped access
//   outstanding                   number of tracked (not yet returned) reads
module gecko_data_router #(
   parameter logic [31:0] MMIO_BASE       = 32'hFFFF_0000,
   parameter int          MMIO_ADDR_WIDTH = 8,
   parameter int          MEM_ADDR_WIDTH  = 16,
   parameter int          TRACK_DEPTH     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   // core request
   input  logic                           core_request_valid,
   output logic                           core_request_ready,
   input  logic                           core_request_read_enable,
   input  logic [3:0]                     core_request_write_enable,
   input  logic [31:0]                    core_request_addr,
   input  logic [31:0]                    core_request_data,
   // core result
   output logic                           core_result_valid,
   input  logic                           core_result_ready,
   output logic [31:0]                    core_result_data,
   // main memory
   output logic                           mem_command_valid,
   input  logic                           mem_command_ready,
   output logic                           mem_command_read_enable,
   output logic [3:0]                     mem_command_write_enable,
   output logic [31:0]                    mem_command_addr,
   output logic [31:0]                    mem_command_data,
   input  logic                           mem_result_valid,
   output logic                           mem_result_ready,
   input  logic [31:0]                    mem_result_data,
   // MMIO
   output logic                           mmio_command_valid,
   input  logic                           mmio_command_ready,
   output logic                           mmio_command_read_enable,
   output logic [3:0]                     mmio_command_write_enable,
   output logic [31:0]                    mmio_command_addr,
   output logic [31:0]                    mmio_command_data,
   input  logic                           mmio_result_valid,
   output logic                           mmio_result_ready,
   input  logic [31:0]                    mmio_result_data,
   // status
   output logic                           fault_flag,
   output logic [$clog2(TRACK_DEPTH):0]   outstanding
);

   localparam int PW = $clog2(TRACK_DEPTH);
   localparam logic [PW:0] ONE   = (PW+1)'(1);
   localparam logic [PW:0] DEPTH = (PW+1)'(TRACK_DEPTH);

   typedef enum logic [1:0] {
      DEST_MEM      = 2'd0,
      DEST_MMIO     = 2'd1,
      DEST_UNMAPPED = 2'd2
   } dest_e;

   dest_e       track_q [TRACK_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr, count;
   logic        full, empty;
   logic        is_mem, is_mmio, is_read, blocked;
   logic        accept, push, pop;
   dest_e       dest, head;

   assign full  = (count == DEPTH);
   assign empty = (count == '0);
   assign head  = track_q[rd_ptr[PW-1:0]];

   // Address decode; memory wins if the two windows overlap.
   assign is_mem  = (core_request_addr[31:MEM_ADDR_WIDTH] == '0);
   assign is_mmio = !is_mem &&
                    (core_request_addr[31:MMIO_ADDR_WIDTH] == MMIO_BASE[31:MMIO_ADDR_WIDTH]);
   assign dest    = is_mem ? DEST_MEM : (is_mmio ? DEST_MMIO : DEST_UNMAPPED);

   // Only reads need a tracking slot, so only reads are held off by full.
   // Full is taken from the registered count, so a same-cycle pop does not
   // free a slot and core_result_ready never reaches core_request_ready.
   assign is_read = core_request_read_enable;
   assign blocked = is_read && full;

   always_comb begin
      core_request_ready = 1'b0;
      case (dest)
         DEST_MEM:  core_request_ready = mem_command_ready  && !blocked;
         DEST_MMIO: core_request_ready = mmio_command_ready && !blocked;
         default:   core_request_ready = !blocked;
      endcase
   end

   // Command paths are pure pass-through; only valid is steered. Valids are
   // also held low while reset is asserted.
   assign mem_command_valid         = rst && core_request_valid && is_mem  && !blocked;
   assign mmio_command_valid        = rst && core_request_valid && is_mmio && !blocked;
   assign mem_command_read_enable   = core_request_read_enable;
   assign mem_command_write_enable  = core_request_write_enable;
   assign mem_command_addr          = core_request_addr;
   assign mem_command_data          = core_request_data;
   assign mmio_command_read_enable  = core_request_read_enable;
   assign mmio_command_write_enable = core_request_write_enable;
   assign mmio_command_addr         = core_request_addr;
   assign mmio_command_data         = core_request_data;

   assign accept = core_request_valid && core_request_ready;
   assign push   = accept && is_read;

   // Result steering from the FIFO head. A target whose result is not at the
   // head sees ready=0 and must hold it.
   always_comb begin
      core_result_valid = 1'b0;
      core_result_data  = '0;
      mem_result_ready  = 1'b0;
      mmio_result_ready = 1'b0;
      if (!empty) begin
         case (head)
            DEST_MEM: begin
               core_result_valid = mem_result_valid;
               core_result_data  = mem_result_data;
               mem_result_ready  = core_result_ready;
            end
            DEST_MMIO: begin
               core_result_valid = mmio_result_valid;
               core_result_data  = mmio_result_data;
               mmio_result_ready = core_result_ready;
            end
            default: begin
               // unmapped reads complete immediately with zero data
               core_result_valid = 1'b1;
               core_result_data  = '0;
            end
         endcase
      end
   end

   assign pop = core_result_valid && core_result_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fault_flag <= 1'b0;
         for (int i = 0; i < TRACK_DEPTH; i++) track_q[i] <= DEST_MEM;
      end else begin
         if (push) begin
            track_q[wr_ptr[PW-1:0]] <= dest;
            wr_ptr                  <= wr_ptr + ONE;
         end
         if (pop) rd_ptr <= rd_ptr + ONE;
         case ({push, pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         if (accept && dest == DEST_UNMAPPED) fault_flag <= 1'b1;
      end
   end

   assign outstanding = count;

endmodule

// File: tb/tb_gecko_data_router.sv
module tb_gecko_data_router;

   logic        clk, rst;
   logic        core_request_valid, core_request_ready, core_request_read_enable;
   logic [3:0]  core_request_write_enable;
   logic [31:0] core_request_addr, core_request_data;
   logic        core_result_valid, core_result_ready;
   logic [31:0] core_result_data;
   logic        mem_command_valid, mem_command_ready, mem_command_read_enable;
   logic [3:0]  mem_command_write_enable;
   logic [31:0] mem_command_addr, mem_command_data;
   logic        mem_result_valid, mem_result_ready;
   logic [31:0] mem_result_data;
   logic        mmio_command_valid, mmio_command_ready, mmio_command_read_enable;
   logic [3:0]  mmio_command_write_enable;
   logic [31:0] mmio_command_addr, mmio_command_data;
   logic        mmio_result_valid, mmio_result_ready;
   logic [31:0] mmio_result_data;
   logic        fault_flag;
   logic [2:0]  outstanding;

   int n_assert = 0;
   int n_fail   = 0;

   gecko_data_router dut (
      .clk(clk), .rst(rst),
      .core_request_valid(core_request_valid), .core_request_ready(core_request_ready),
      .core_request_read_enable(core_request_read_enable),
      .core_request_write_enable(core_request_write_enable),
      .core_request_addr(core_request_addr), .core_request_data(core_request_data),
      .core_result_valid(core_result_valid), .core_result_ready(core_result_ready),
      .core_result_data(core_result_data),
      .mem_command_valid(mem_command_valid), .mem_command_ready(mem_command_ready),
      .mem_command_read_enable(mem_command_read_enable),
      .mem_command_write_enable(mem_command_write_enable),
      .mem_command_addr(mem_command_addr), .mem_command_data(mem_command_data),
      .mem_result_valid(mem_result_valid), .mem_result_ready(mem_result_ready),
      .mem_result_data(mem_result_data),
      .mmio_command_valid(mmio_command_valid), .mmio_command_ready(mmio_command_ready),
      .mmio_command_read_enable(mmio_command_read_enable),
      .mmio_command_write_enable(mmio_command_write_enable),
      .mmio_command_addr(mmio_command_addr), .mmio_command_data(mmio_command_data),
      .mmio_result_valid(mmio_result_valid), .mmio_result_ready(mmio_result_ready),
      .mmio_result_data(mmio_result_data),
      .fault_flag(fault_flag), .outstanding(outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic rd, input logic [3:0] we, input logic [31:0] a);
      core_request_valid        = 1'b1;
      core_request_read_enable  = rd;
      core_request_write_enable = we;
      core_request_addr         = a;
      core_request_data         = a ^ 32'h5A5A_0000;
   endtask

   task automatic no_req();
      core_request_valid        = 1'b0;
      core_request_read_enable  = 1'b0;
      core_request_write_enable = 4'h0;
   endtask

   initial begin
      rst = 1'b0;
      no_req();
      core_request_addr  = '0;
      core_request_data  = '0;
      core_result_ready  = 1'b1;
      mem_command_ready  = 1'b1;
      mmio_command_ready = 1'b1;
      mem_result_valid   = 1'b0;
      mem_result_data    = '0;
      mmio_result_valid  = 1'b0;
      mmio_result_data   = '0;

      // ---- reset state
      tick(); tick();
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_fault", 32'(fault_flag), 0);
      chk("rst_result_valid", 32'(core_result_valid), 0);
      rst = 1'b1;
      tick();

      // ---- single MEM read, memory latency 2
      req(1'b1, 4'h0, 32'h0000_0010);
      #1;
      chk("t1_req_ready", 32'(core_request_ready), 1);
      chk("t1_mem_valid", 32'(mem_command_valid), 1);
      chk("t1_mmio_valid", 32'(mmio_command_valid), 0);
      chk("t1_mem_addr", mem_command_addr, 32'h0000_0010);
      tick(); no_req(); #1;
      chk("t1_outst_1", 32'(outstanding), 1);
      chk("t1_no_result_yet", 32'(core_result_valid), 0);
      tick();
      mem_result_valid = 1'b1; mem_result_data = 32'hDEAD_BEEF; #1;
      chk("t1_res_valid", 32'(core_result_valid), 1);
      chk("t1_res_data", core_result_data, 32'hDEAD_BEEF);
      chk("t1_mem_res_ready", 32'(mem_result_ready), 1);
      tick(); mem_result_valid = 1'b0; #1;
      chk("t1_outst_0", 32'(outstanding), 0);

      // ---- MEM read (slow) then MMIO read (fast): in-order return
      req(1'b1, 4'h0, 32'h0000_0020);
      tick();
      req(1'b1, 4'h0, 32'hFFFF_0004); #1;
      chk("t2_mmio_valid", 32'(mmio_command_valid), 1);
      chk("t2_mem_valid", 32'(mem_command_valid), 0);
      chk("t2_req_ready", 32'(core_request_ready), 1);
      tick(); no_req();
      mmio_result_valid = 1'b1; mmio_result_data = 32'h11; #1;
      chk("t2_outst_2", 32'(outstanding), 2);
      chk("t2_mmio_held", 32'(mmio_result_ready), 0);
      chk("t2_no_result", 32'(core_result_valid), 0);
      tick(); tick(); #1;
      chk("t2_mmio_held2", 32'(mmio_result_ready), 0);
      mem_result_valid = 1'b1; mem_result_data = 32'hCAFE_0001; #1;
      chk("t2_first_data", core_result_data, 32'hCAFE_0001);
      chk("t2_mmio_held3", 32'(mmio_result_ready), 0);
      tick(); mem_result_valid = 1'b0; #1;
      chk("t2_second_valid", 32'(core_result_valid), 1);
      chk("t2_second_data", core_result_data, 32'h11);
      chk("t2_mmio_ready", 32'(mmio_result_ready), 1);
      tick(); mmio_result_valid = 1'b0; #1;
      chk("t2_outst_0", 32'(outstanding), 0);

      // ---- unmapped write then unmapped read
      req(1'b0, 4'hF, 32'h0002_0000); #1;
      chk("t3_wr_ready", 32'(core_request_ready), 1);
      chk("t3_no_mem_cmd", 32'(mem_command_valid), 0);
      chk("t3_no_mmio_cmd", 32'(mmio_command_valid), 0);
      chk("t3_fault_before", 32'(fault_flag), 0);
      tick(); no_req(); #1;
      chk("t3_fault_set", 32'(fault_flag), 1);
      chk("t3_wr_no_track", 32'(outstanding), 0);
      req(1'b1, 4'h0, 32'h0002_0000); #1;
      chk("t3_rd_ready", 32'(core_request_ready), 1);
      tick(); no_req(); #1;
      chk("t3_rd_outst", 32'(outstanding), 1);
      chk("t3_rd_valid", 32'(core_result_valid), 1);
      chk("t3_rd_zero", core_result_data, 32'h0);
      chk("t3_no_tgt_ready", 32'(mem_result_ready | mmio_result_ready), 0);
      tick(); #1;
      chk("t3_outst_0", 32'(outstanding), 0);

      // ---- fill the tracker with result path stalled
      core_result_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req(1'b1, 4'h0, 32'h100 + 32'(4 * i)); #1;
         chk("t4_fill_ready", 32'(core_request_ready), 1);
         tick();
      end
      req(1'b1, 4'h0, 32'h110); #1;
      chk("t4_full_stall", 32'(core_request_ready), 0);
      chk("t4_full_no_cmd", 32'(mem_command_valid), 0);
      chk("t4_outst_4", 32'(outstanding), 4);
      req(1'b0, 4'h3, 32'h200); #1;
      chk("t4_wr_ready", 32'(core_request_ready), 1);
      chk("t4_wr_cmd", 32'(mem_command_valid), 1);
      tick(); #1;
      chk("t4_outst_still4", 32'(outstanding), 4);
      // a pop in the same cycle does not unblock a read
      req(1'b1, 4'h0, 32'h110);
      core_result_ready = 1'b1; mem_result_valid = 1'b1; mem_result_data = 32'hA0; #1;
      chk("t4_pop_valid", 32'(core_result_valid), 1);
      chk("t4_pop_still_full", 32'(core_request_ready), 0);
      tick(); no_req(); #1;
      chk("t4_outst_3", 32'(outstanding), 3);
      for (int i = 1; i < 4; i++) begin
         mem_result_data = 32'hA0 + 32'(i); #1;
         chk("t4_drain_data", core_result_data, 32'hA0 + 32'(i));
         tick();
      end
      mem_result_valid = 1'b0; #1;
      chk("t4_outst_0", 32'(outstanding), 0);

      // ---- streaming: push and pop every cycle, pointers wrap
      for (int i = 0; i <= 10; i++) begin
         if (i < 10) req(1'b1, 4'h0, 32'h400 + 32'(4 * i));
         else no_req();
         if (i > 0) begin
            mem_result_valid = 1'b1;
            mem_result_data  = 32'h5000 + 32'(i - 1);
         end
         #1;
         if (i < 10) chk("t5_ready", 32'(core_request_ready), 1);
         if (i > 0) begin
            chk("t5_valid", 32'(core_result_valid), 1);
            chk("t5_data", core_result_data, 32'h5000 + 32'(i - 1));
            chk("t5_outst_1", 32'(outstanding), 1);
         end
         tick();
      end
      mem_result_valid = 1'b0; #1;
      chk("t5_outst_0", 32'(outstanding), 0);

      // ---- reset mid-stream with 3 reads outstanding
      core_result_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req(1'b1, 4'h0, 32'h800 + 32'(4 * i));
         tick();
      end
      #1;
      chk("t6_outst_3", 32'(outstanding), 3);
      rst = 1'b0; #1;
      chk("t6_rst_outst", 32'(outstanding), 0);
      chk("t6_rst_fault", 32'(fault_flag), 0);
      chk("t6_rst_res_valid", 32'(core_result_valid), 0);
      chk("t6_rst_cmd_valid", 32'(mem_command_valid), 0);
      no_req();
      tick();
      rst = 1'b1; core_result_ready = 1'b1;
      tick();
      req(1'b1, 4'h0, 32'h900); #1;
      chk("t6_resume_ready", 32'(core_request_ready), 1);
      tick(); no_req();
      mem_result_valid = 1'b1; mem_result_data = 32'h77; #1;
      chk("t6_resume_data", core_result_data, 32'h77);
      tick(); mem_result_valid = 1'b0; #1;
      chk("t6_resume_outst0", 32'(outstanding), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
